prt_riscv_lib_edge_det: RTL and testbench
=========================================

// Module: prt_riscv_lib_edge_det
// PURPOSE
// Multi-channel edge detector for RISC-V peripheral inputs (GPIO, status pins, IRQ lines).
// Per channel: optional N-stage input synchroniser, then a glitch filter (debounce), then registered edge pulses.
// Each channel has a selectable sticky event flag with per-bit clear; all flags OR into one interrupt output.
// PARAMETERS
// P_CHANNELS     8   number of independent input channels (1..32)
// P_SYNC_STAGES  2   synchroniser flops per channel; 0 = bypass (A_IN used directly)
// P_FILTER_LEN   4   consecutive enabled cycles an input must differ before it is accepted (1 = no filtering, max 255)
// PORTS
// CLK_IN       in   1             clock
// RST_IN       in   1             reset; synchronous, active-high
// CKE_IN       in   1             clock enable for synchroniser, filter and edge logic
// A_IN         in   P_CHANNELS    raw inputs, asynchronous when P_SYNC_STAGES>0
// EDGE_SEL_IN  in   2*P_CHANNELS  per channel [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both
// CLR_IN       in   P_CHANNELS    per-channel event clear; single-cycle pulse or level
// STA_OUT      out  P_CHANNELS    filtered input level
// RE_OUT       out  P_CHANNELS    rising-edge pulse, one cycle
// FE_OUT       out  P_CHANNELS    falling-edge pulse, one cycle
// EVT_OUT      out  P_CHANNELS    sticky event flags
// IRQ_OUT      out  1             OR of EVT_OUT (combinational)
// BEHAVIOUR
// - Reset: sync flops, filter counters, STA_OUT, RE_OUT, FE_OUT and EVT_OUT all clear to 0. IRQ_OUT therefore reads 0.
// - Sync: s[c] is A_IN[c] after P_SYNC_STAGES flops. The flops advance only when CKE_IN=1.
// - Filter, per channel, counter width $clog2(P_FILTER_LEN+1), evaluated on edges with CKE_IN=1:
//   - s==STA: counter cleared to 0.
//   - s!=STA and counter < P_FILTER_LEN-1: counter increments.
//   - s!=STA and counter == P_FILTER_LEN-1: commit. STA <= s and the counter clears.
// - Edges: on a commit edge, RE_OUT[c] <= s (rising) and FE_OUT[c] <= !s (falling).
//   RE_OUT/FE_OUT are 0 on every other edge, including edges with CKE_IN=0.
//   Pulses are exactly one clock wide. RE and FE are never set together.
// - Latency: A_IN held stable from sampling edge 1 gives STA/RE/FE updates at edge P_SYNC_STAGES+P_FILTER_LEN.
//   Each CKE_IN=0 edge adds one edge of delay.
// - Glitch: a change shorter than P_FILTER_LEN enabled cycles leaves STA unchanged, with no pulse and no event.
// - Events: EVT[c] sets on the commit edge when the edge type matches EDGE_SEL.
//   EVT[c] clears on any edge with CLR_IN[c]=1. CLR_IN is not gated by CKE_IN.
//   Simultaneous set and clear: set wins.
//   EDGE_SEL changes take effect at the next commit; existing flags are not affected.
// - Channels are fully independent; simultaneous events on several channels are all captured.
// - Reset mid-filter discards the partial count. A_IN high through reset produces a rising edge P_SYNC_STAGES+P_FILTER_LEN edges after release.
// TESTING (P_CHANNELS=8, P_SYNC_STAGES=2, P_FILTER_LEN=4, CKE_IN=1 unless stated)
// 1. Reset with A_IN=0, then A_IN[0]=1 held: outputs 0 during reset; RE_OUT[0]=1 for 1 cycle at edge 6, with STA_OUT[0]=1 from the same edge.
// 2. A_IN[1] high for 3 cycles, then low: STA_OUT[1], RE_OUT[1] and FE_OUT[1] stay 0.
// 3. EDGE_SEL[5:4]=10, A_IN[2] 0->1->0 (each held 10 cycles): RE pulse with EVT[2]=0; FE pulse sets EVT[2]=1 and IRQ_OUT=1.
//    Then CLR_IN[2]=1 for 1 cycle: EVT[2]=0 and IRQ_OUT=0 on the next edge.
// 4. CLR_IN[3]=1 on the same edge a selected edge commits on channel 3: EVT[3]=1 afterwards.
// 5. CKE_IN low for 3 cycles mid-filter on channel 4: RE_OUT[4] arrives 3 edges later than in test 1 (edge 9); no pulse while CKE_IN=0.
// 6. EVT[0..7] all set with A_IN=8'hFF, then RST_IN 1 cycle: all outputs 0 at the next edge; RE_OUT=8'hFF exactly 6 edges after reset release.

Source files
------------

// File: rtl/prt_riscv_lib_edge_det.sv
// prt_riscv_lib_edge_det: multi-channel synchronised, debounced edge detector with sticky events and IRQ
module prt_riscv_lib_edge_det #(
  parameter int P_CHANNELS    = 8,
  parameter int P_SYNC_STAGES = 2,
  parameter int P_FILTER_LEN  = 4
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  input  logic                    CKE_IN,
  input  logic [P_CHANNELS-1:0]   A_IN,
  input  logic [2*P_CHANNELS-1:0] EDGE_SEL_IN,
  input  logic [P_CHANNELS-1:0]   CLR_IN,
  output logic [P_CHANNELS-1:0]   STA_OUT,
  output logic [P_CHANNELS-1:0]   RE_OUT,
  output logic [P_CHANNELS-1:0]   FE_OUT,
  output logic [P_CHANNELS-1:0]   EVT_OUT,
  output logic                    IRQ_OUT
);
  localparam int LP_CW = $clog2(P_FILTER_LEN + 1);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(P_FILTER_LEN - 1);
  logic [P_CHANNELS-1:0] w_s, w_commit, w_match;
  logic [P_CHANNELS-1:0] r_sta, r_re, r_fe, r_evt;
  logic [LP_CW-1:0]      r_cnt [P_CHANNELS];
  generate
    if (P_SYNC_STAGES > 0) begin : g_sync
      logic [P_CHANNELS-1:0] r_sync [P_SYNC_STAGES];
      always_ff @(posedge CLK_IN)
        if (RST_IN) begin
          for (int i = 0; i < P_SYNC_STAGES; i++) r_sync[i] <= '0;
        end else if (CKE_IN) begin
          r_sync[0] <= A_IN;
          for (int i = 1; i < P_SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      assign w_s = r_sync[P_SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_s = A_IN;
    end
  endgenerate
  // A commit happens on the enabled edge where the input has differed for the full filter length
  always_comb begin
    w_commit = '0;
    w_match  = '0;
    for (int c = 0; c < P_CHANNELS; c++) begin
      w_commit[c] = CKE_IN && (w_s[c] != r_sta[c]) && (r_cnt[c] == LP_LAST);
      w_match[c]  = w_s[c] ? EDGE_SEL_IN[2*c] : EDGE_SEL_IN[2*c+1];
    end
  end
  always_ff @(posedge CLK_IN)
    if (RST_IN) begin
      r_sta <= '0;
      r_re  <= '0;
      r_fe  <= '0;
      r_evt <= '0;
      for (int c = 0; c < P_CHANNELS; c++) r_cnt[c] <= '0;
    end else begin
      r_re  <= w_commit & w_s;
      r_fe  <= w_commit & ~w_s;
      r_sta <= r_sta ^ w_commit;
      r_evt <= (r_evt & ~CLR_IN) | (w_commit & w_match);
      if (CKE_IN)
        for (int c = 0; c < P_CHANNELS; c++)
          r_cnt[c] <= (w_s[c] == r_sta[c] || w_commit[c]) ? '0 : r_cnt[c] + 1'b1;
    end
  assign STA_OUT = r_sta;
  assign RE_OUT  = r_re;
  assign FE_OUT  = r_fe;
  assign EVT_OUT = r_evt;
  assign IRQ_OUT = |r_evt;
endmodule

// File: tb/tb_prt_riscv_lib_edge_det.sv
// tb_prt_riscv_lib_edge_det: directed stimulus, per-cycle behavioural model compare plus literal checkpoints
module tb_prt_riscv_lib_edge_det;
  localparam int CH = 8;
  localparam int SS = 2;
  localparam int FL = 4;
  logic          clk = 0;
  logic          rst = 1;
  logic          cke = 1;
  logic [CH-1:0] a   = '0;
  logic [2*CH-1:0] sel = '0;
  logic [CH-1:0] clr = '0;
  logic [CH-1:0] sta, re, fe, evt;
  logic          irq;
  int n_chk = 0;
  int n_err = 0;

  prt_riscv_lib_edge_det #(.P_CHANNELS(CH), .P_SYNC_STAGES(SS), .P_FILTER_LEN(FL)) dut (
    .CLK_IN(clk), .RST_IN(rst), .CKE_IN(cke), .A_IN(a), .EDGE_SEL_IN(sel), .CLR_IN(clr),
    .STA_OUT(sta), .RE_OUT(re), .FE_OUT(fe), .EVT_OUT(evt), .IRQ_OUT(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: input delayed by SS enabled edges, then a run-length of disagreeing samples
  bit [CH-1:0] m_pipe [SS];
  bit [CH-1:0] m_sta, m_re, m_fe, m_evt, m_s, m_com, m_match;
  int          m_run [CH];
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) m_pipe[i] = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
      m_sta = '0; m_re = '0; m_fe = '0; m_evt = '0;
      m_valid = 1;
    end else begin
      m_s = m_pipe[SS-1];
      m_com = '0;
      for (int c = 0; c < CH; c++) begin
        m_match[c] = m_s[c] ? sel[2*c] : sel[2*c+1];
        if (cke) begin
          m_run[c] = (m_s[c] != m_sta[c]) ? m_run[c] + 1 : 0;
          if (m_run[c] == FL) begin
            m_com[c] = 1;
            m_run[c] = 0;
          end
        end
      end
      m_re  = m_com & m_s;
      m_fe  = m_com & ~m_s;
      m_sta = m_sta ^ m_com;
      m_evt = (m_evt & ~clr) | (m_com & m_match);
      if (cke) begin
        for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = a;
      end
    end
  end

  always @(negedge clk)
    if (m_valid) begin
      check("model_sta", 32'(sta), 32'(m_sta));
      check("model_re",  32'(re),  32'(m_re));
      check("model_fe",  32'(fe),  32'(m_fe));
      check("model_evt", 32'(evt), 32'(m_evt));
      check("model_irq", 32'(irq), 32'(|m_evt));
    end

  logic [CH-1:0] acc;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_all", {sta, re, fe, evt, irq}, 0);
    // 1: rising edge latency after reset release
    rst = 0;
    a[0] = 1;
    repeat (5) @(negedge clk);
    check("t1_re_before", 32'(re[0]), 0);
    check("t1_sta_before", 32'(sta[0]), 0);
    @(negedge clk);
    check("t1_re_edge6", 32'(re[0]), 1);
    check("t1_sta_edge6", 32'(sta[0]), 1);
    @(negedge clk);
    check("t1_re_width", 32'(re[0]), 0);
    // 2: glitch of 3 cycles is rejected
    a[1] = 1;
    repeat (3) @(negedge clk);
    a[1] = 0;
    acc = '0;
    repeat (10) begin
      @(negedge clk);
      acc = acc | sta | re | fe;
    end
    check("t2_glitch", 32'(acc[1]), 0);
    // 3: falling-only selection, then clear
    sel[5:4] = 2'b10;
    a[2] = 1;
    repeat (10) @(negedge clk);
    check("t3_sta_hi", 32'(sta[2]), 1);
    check("t3_evt_rise", 32'(evt[2]), 0);
    a[2] = 0;
    repeat (10) @(negedge clk);
    check("t3_evt_fall", 32'(evt[2]), 1);
    check("t3_irq_set", 32'(irq), 1);
    clr[2] = 1;
    @(negedge clk);
    clr[2] = 0;
    check("t3_evt_clr", 32'(evt[2]), 0);
    check("t3_irq_clr", 32'(irq), 0);
    // 4: set wins over simultaneous clear
    sel[7:6] = 2'b11;
    a[3] = 1;
    repeat (5) @(negedge clk);
    clr[3] = 1;
    @(negedge clk);
    clr[3] = 0;
    check("t4_re", 32'(re[3]), 1);
    check("t4_evt_set_wins", 32'(evt[3]), 1);
    @(negedge clk);
    check("t4_evt_hold", 32'(evt[3]), 1);
    // 5: clock enable stall adds 3 edges
    a[4] = 1;
    repeat (3) @(negedge clk);
    cke = 0;
    acc = '0;
    repeat (3) begin
      @(negedge clk);
      acc = acc | re | fe;
    end
    check("t5_no_pulse_stalled", 32'(acc), 0);
    cke = 1;
    repeat (2) @(negedge clk);
    check("t5_re_early", 32'(re[4]), 0);
    @(negedge clk);
    check("t5_re_edge9", 32'(re[4]), 1);
    // 6: all events, reset, then rising edges from held-high inputs
    sel = '1;
    a = '0;
    repeat (10) @(negedge clk);
    a = '1;
    repeat (10) @(negedge clk);
    check("t6_evt_all", 32'(evt), 32'hFF);
    check("t6_irq", 32'(irq), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6_reset_all", {sta, re, fe, evt, irq}, 0);
    repeat (5) @(negedge clk);
    check("t6_re_before", 32'(re), 0);
    @(negedge clk);
    check("t6_re_all", 32'(re), 32'hFF);
    check("t6_sta_all", 32'(sta), 32'hFF);
    @(negedge clk);
    check("t6_re_width", 32'(re), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
